// File: rtl/dct2d_seq_ctrl.sv
// dct2d_seq_ctrl: row/column sequencer sharing one 8-point DCT engine for an 8x8 2-D DCT
module dct2d_seq_ctrl #(
  parameter int IN_W = 32,
  parameter int FRAC = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [7:0]             s_px0,
  input  logic [7:0]             s_px1,
  input  logic [7:0]             s_px2,
  input  logic [7:0]             s_px3,
  input  logic [7:0]             s_px4,
  input  logic [7:0]             s_px5,
  input  logic [7:0]             s_px6,
  input  logic [7:0]             s_px7,
  output logic                   dct_in_valid,
  input  logic                   dct_in_ready,
  output logic signed [IN_W-1:0] dct_in0,
  output logic signed [IN_W-1:0] dct_in1,
  output logic signed [IN_W-1:0] dct_in2,
  output logic signed [IN_W-1:0] dct_in3,
  output logic signed [IN_W-1:0] dct_in4,
  output logic signed [IN_W-1:0] dct_in5,
  output logic signed [IN_W-1:0] dct_in6,
  output logic signed [IN_W-1:0] dct_in7,
  input  logic                   dct_out_valid,
  output logic                   dct_out_ready,
  input  logic signed [IN_W-1:0] dct_out0,
  input  logic signed [IN_W-1:0] dct_out1,
  input  logic signed [IN_W-1:0] dct_out2,
  input  logic signed [IN_W-1:0] dct_out3,
  input  logic signed [IN_W-1:0] dct_out4,
  input  logic signed [IN_W-1:0] dct_out5,
  input  logic signed [IN_W-1:0] dct_out6,
  input  logic signed [IN_W-1:0] dct_out7,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic signed [IN_W-1:0] m_d0,
  output logic signed [IN_W-1:0] m_d1,
  output logic signed [IN_W-1:0] m_d2,
  output logic signed [IN_W-1:0] m_d3,
  output logic signed [IN_W-1:0] m_d4,
  output logic signed [IN_W-1:0] m_d5,
  output logic signed [IN_W-1:0] m_d6,
  output logic signed [IN_W-1:0] m_d7,
  output logic [2:0]             m_col,
  output logic                   m_last
);
  typedef enum logic {S_ROW, S_COL} state_t;
  state_t state_q, state_d;
  logic [3:0] ri_q, ri_d, rd_q, rd_d, ci_q, ci_d, cd_q, cd_d;
  logic [IN_W-1:0] buf_q [8][8];
  logic [7:0] px [8];
  logic [IN_W-1:0] dout [8];
  logic [IN_W-1:0] din [8];
  logic row, in_xfer, out_xfer, m_xfer;
  // gather the flat ports into lane arrays and drive the flat outputs back
  always_comb begin
    px[0] = s_px0; px[1] = s_px1; px[2] = s_px2; px[3] = s_px3;
    px[4] = s_px4; px[5] = s_px5; px[6] = s_px6; px[7] = s_px7;
    dout[0] = dct_out0; dout[1] = dct_out1; dout[2] = dct_out2; dout[3] = dct_out3;
    dout[4] = dct_out4; dout[5] = dct_out5; dout[6] = dct_out6; dout[7] = dct_out7;
    dct_in0 = din[0]; dct_in1 = din[1]; dct_in2 = din[2]; dct_in3 = din[3];
    dct_in4 = din[4]; dct_in5 = din[5]; dct_in6 = din[6]; dct_in7 = din[7];
    m_d0 = dct_out0; m_d1 = dct_out1; m_d2 = dct_out2; m_d3 = dct_out3;
    m_d4 = dct_out4; m_d5 = dct_out5; m_d6 = dct_out6; m_d7 = dct_out7;
  end
  // handshakes and engine input mux; rows are level-shifted pixels, columns come from the buffer
  always_comb begin
    row = state_q == S_ROW;
    s_ready = row && dct_in_ready && !ri_q[3];
    dct_in_valid = row ? s_valid && !ri_q[3] : !ci_q[3];
    dct_out_ready = row || m_ready;
    m_valid = !row && dct_out_valid;
    m_col = cd_q[2:0];
    m_last = cd_q == 4'd7;
    in_xfer = dct_in_valid && dct_in_ready;
    out_xfer = dct_out_valid && dct_out_ready;
    m_xfer = m_valid && m_ready;
    for (int k = 0; k < 8; k++)
      din[k] = row ? (IN_W'(px[k]) - IN_W'(128)) << FRAC : buf_q[k][ci_q[2:0]];
  end
  // pass sequencing: switch to columns the cycle after the 8th row result lands
  always_comb begin
    state_d = state_q;
    ri_d = ri_q;
    rd_d = rd_q;
    ci_d = ci_q;
    cd_d = cd_q;
    if (row) begin
      ri_d = rd_q[3] ? 4'd0 : ri_q + 4'(in_xfer);
      rd_d = rd_q[3] ? 4'd0 : rd_q + 4'(out_xfer);
      state_d = rd_q[3] ? S_COL : S_ROW;
    end else begin
      ci_d = (m_xfer && cd_q == 4'd7) ? 4'd0 : ci_q + 4'(in_xfer);
      cd_d = (m_xfer && cd_q == 4'd7) ? 4'd0 : cd_q + 4'(m_xfer);
      state_d = (m_xfer && cd_q == 4'd7) ? S_ROW : S_COL;
    end
  end
  // state and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_ROW;
      ri_q <= '0;
      rd_q <= '0;
      ci_q <= '0;
      cd_q <= '0;
    end else begin
      state_q <= state_d;
      ri_q <= ri_d;
      rd_q <= rd_d;
      ci_q <= ci_d;
      cd_q <= cd_d;
    end
  end
  // transpose buffer: row results stored by row index, read back column-wise
  always_ff @(posedge clk) begin
    if (row && out_xfer && !rd_q[3])
      for (int k = 0; k < 8; k++) buf_q[rd_q[2:0]][k] <= dout[k];
  end
endmodule

// File: tb/tb_dct2d_seq_ctrl.sv
// tb_dct2d_seq_ctrl: randomized directed bench with engine model and 2-D reference
module tb_dct2d_seq_ctrl;
  localparam int W = 32;
  logic clk = 0, rst_n = 0;
  logic s_valid = 0, s_ready, dct_in_valid, dct_in_ready, dct_out_valid, dct_out_ready;
  logic m_valid, m_ready = 1, m_last;
  logic [2:0] m_col;
  logic [7:0] px [8];
  logic [W-1:0] din [8], dout [8], md [8];
  int n_assert = 0, n_fail = 0;
  int lat = 1, cnt;
  bit mix = 0, gaps = 0;
  logic [7:0] p [8][8];
  logic [W-1:0] x [8][8], y [8][8], z [8][8];
  always #5 clk = ~clk;
  dct2d_seq_ctrl #(.IN_W(W), .FRAC(8)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_px0(px[0]), .s_px1(px[1]), .s_px2(px[2]), .s_px3(px[3]),
    .s_px4(px[4]), .s_px5(px[5]), .s_px6(px[6]), .s_px7(px[7]),
    .dct_in_valid(dct_in_valid), .dct_in_ready(dct_in_ready),
    .dct_in0(din[0]), .dct_in1(din[1]), .dct_in2(din[2]), .dct_in3(din[3]),
    .dct_in4(din[4]), .dct_in5(din[5]), .dct_in6(din[6]), .dct_in7(din[7]),
    .dct_out_valid(dct_out_valid), .dct_out_ready(dct_out_ready),
    .dct_out0(dout[0]), .dct_out1(dout[1]), .dct_out2(dout[2]), .dct_out3(dout[3]),
    .dct_out4(dout[4]), .dct_out5(dout[5]), .dct_out6(dout[6]), .dct_out7(dout[7]),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_d0(md[0]), .m_d1(md[1]), .m_d2(md[2]), .m_d3(md[3]),
    .m_d4(md[4]), .m_d5(md[5]), .m_d6(md[6]), .m_d7(md[7]),
    .m_col(m_col), .m_last(m_last)
  );
  // engine transform: identity, or a lane-mixing map that exposes transpose errors
  function automatic logic [W-1:0] ef(input logic [W-1:0] v [8], input int k);
    return mix ? v[k] * (k + 1) + v[(k + 1) % 8] : v[k];
  endfunction
  // single-outstanding engine with configurable turnaround, sharing the reset
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 0;
      dct_out_valid <= 0;
    end else begin
      if (dct_out_valid && dct_out_ready) dct_out_valid <= 0;
      if (dct_in_valid && dct_in_ready) begin
        for (int k = 0; k < 8; k++) dout[k] <= ef(din, k);
        cnt <= lat;
      end else if (cnt == 1) begin
        cnt <= 0;
        dct_out_valid <= 1;
      end else if (cnt > 1) cnt <= cnt - 1;
    end
  end
  assign dct_in_ready = (cnt == 0) && !dct_out_valid;
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_assert++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask
  // build pixels and the expected coefficients: rows through the engine, then columns
  task automatic make_block(input int mode);
    logic [W-1:0] v [8];
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        p[r][c] = mode == 0 ? 8'd128 : mode == 1 ? 8'(8 * r + c) : 8'($urandom_range(255, 0));
        x[r][c] = (int'(p[r][c]) - 128) * 256;
      end
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 8; k++) v[k] = x[r][k];
      for (int k = 0; k < 8; k++) y[r][k] = ef(v, k);
    end
    for (int c = 0; c < 8; c++) begin
      for (int r = 0; r < 8; r++) v[r] = y[r][c];
      for (int r = 0; r < 8; r++) z[c][r] = ef(v, r);
    end
  endtask
  // assert reset and check the values the block shows while held in reset
  task automatic reset_pulse();
    @(negedge clk);
    rst_n = 0;
    m_ready = 1;
    s_valid = 1;
    #1;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_m_col", m_col, 0);
    chk("rst_dct_out_ready", dct_out_ready, 1);
    chk("rst_s_ready", s_ready, 1);
    chk("rst_in_valid_hi", dct_in_valid, 1);
    s_valid = 0;
    #1;
    chk("rst_in_valid_lo", dct_in_valid, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask
  // drive one block and score every coefficient beat; abort_at>0 resets after that many engine issues
  task automatic run_block(input int mode, input bit b2b, input int abort_at, input bit stall);
    int sc = 0, ic = 0, beats = 0, cyc = 0, row = 0, scnt = 0;
    bit sx, ix, mx, stalled = 0;
    make_block(mode);
    s_valid = 1;
    for (int k = 0; k < 8; k++) px[k] = p[0][k];
    while (beats < 8 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (abort_at > 0 && ic == abort_at) begin
        reset_pulse();
        return;
      end
      if (stall && !stalled && beats == 2 && m_valid) begin
        m_ready = 0;
        scnt = 20;
        stalled = 1;
      end else if (gaps && scnt == 0) m_ready = ($urandom % 4) != 0;
      #1;
      if (b2b && cyc == 1) chk("b2b_s_ready", s_ready, 1);
      if (scnt > 0) begin
        chk("stall_m_valid", m_valid, 1);
        chk("stall_out_ready", dct_out_ready, 0);
        for (int k = 0; k < 8; k++) chk($sformatf("stall_d%0d", k), md[k], z[2][k]);
        scnt--;
        if (scnt == 0) m_ready = 1;
      end
      chk("s_ready_gate", s_ready & ~dct_in_ready, 0);
      if (sc < 8) begin
        chk("row_m_valid", m_valid, 0);
        chk("row_in_valid", dct_in_valid, s_valid);
        if (s_valid)
          for (int k = 0; k < 8; k++) chk($sformatf("lvl_r%0d_k%0d", row, k), din[k], x[row][k]);
      end else chk("s_ready_after8", s_ready, 0);
      sx = s_valid && s_ready;
      ix = dct_in_valid && dct_in_ready;
      mx = m_valid && m_ready;
      if (mx) begin
        chk("m_col", m_col, beats);
        chk("m_last", m_last, beats == 7);
        for (int k = 0; k < 8; k++) chk($sformatf("beat%0d_lane%0d", beats, k), md[k], z[beats][k]);
        beats++;
      end
      @(posedge clk);
      #1;
      sc += int'(sx);
      ic += int'(ix);
      if (sx) row++;
      if (sx || !s_valid) begin
        s_valid = row < 8 && (!gaps || ($urandom % 3) != 0);
        if (row < 8) for (int k = 0; k < 8; k++) px[k] = p[row][k];
      end
    end
    s_valid = 0;
    chk("beats_done", beats, 8);
    chk("rows_accepted", sc, 8);
    chk("engine_issues", ic, 16);
  endtask
  initial begin
    for (int k = 0; k < 8; k++) px[k] = 0;
    #2;
    chk("init_m_valid", m_valid, 0);
    chk("init_s_ready", s_ready, dct_in_ready);
    reset_pulse();
    run_block(0, 0, 0, 0);
    run_block(1, 0, 0, 0);
    lat = 6;
    run_block(1, 0, 0, 0);
    lat = 1;
    run_block(1, 0, 0, 1);
    run_block(1, 0, 12, 0);
    run_block(1, 0, 0, 0);
    run_block(0, 0, 0, 0);
    run_block(1, 1, 0, 0);
    mix = 1;
    gaps = 1;
    lat = 3;
    run_block(2, 0, 0, 0);
    run_block(2, 1, 0, 1);
    lat = 1;
    run_block(1, 0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
